// File: rtl/audio_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : audio_sample_fifo
// Brief    : Stereo sample FIFO drained by the DAC word clock (lrck).
// Revision : 1.0
// ============================================================================
module audio_sample_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           in_left,
  input  logic [15:0]           in_right,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  lrck,
  output logic [15:0]           left,
  output logic [15:0]           right,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underrun,
  output logic [7:0]            underrun_count
);

  localparam int                  c_DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [15:0]         c_SILENCE = 16'h8000;
  localparam logic [DEPTH_LOG2:0] c_PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic                  r_lrck_meta;
  logic                  r_lrck_sync;
  logic                  r_lrck_hist;
  logic [DEPTH_LOG2:0]   r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_rd_ptr;
  logic [31:0]           r_mem [c_DEPTH];
  logic [15:0]           r_left;
  logic [15:0]           r_right;
  logic                  r_underrun;
  logic [7:0]            r_underrun_count;

  logic                  w_pop_req;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_underrun;
  logic [DEPTH_LOG2:0]   w_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lrck_meta <= 1'b0;
      r_lrck_sync <= 1'b0;
      r_lrck_hist <= 1'b0;
    end else begin
      r_lrck_meta <= lrck;
      r_lrck_sync <= r_lrck_meta;
      r_lrck_hist <= r_lrck_sync;
    end
  end

  assign w_pop_req  = r_lrck_sync & ~r_lrck_hist;
  assign w_level    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                      (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign w_ready    = ~w_full & ~flush;
  assign w_push     = in_valid & w_ready;
  // Emptiness is judged before this cycle's push, so a same-cycle push cannot satisfy a pop.
  assign w_pop      = w_pop_req & ~w_empty & ~flush;
  assign w_underrun = w_pop_req & w_empty & ~flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= {in_left, in_right};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_left           <= c_SILENCE;
      r_right          <= c_SILENCE;
      r_underrun       <= 1'b0;
      r_underrun_count <= 8'd0;
    end else if (flush) begin
      r_left           <= c_SILENCE;
      r_right          <= c_SILENCE;
      r_underrun       <= 1'b0;
    end else begin
      r_underrun <= w_underrun;
      if (w_pop) begin
        r_left  <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]][31:16];
        r_right <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]][15:0];
      end
      if (w_underrun && (r_underrun_count != 8'hFF)) begin
        r_underrun_count <= r_underrun_count + 8'd1;
      end
    end
  end

  assign in_ready       = w_ready;
  assign left           = r_left;
  assign right          = r_right;
  assign level          = w_level;
  assign underrun       = r_underrun;
  assign underrun_count = r_underrun_count;

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_sample_fifo
// Brief    : Scoreboard bench: queue-based reference model plus decoupled monitor.
// Revision : 1.0
// ============================================================================
module tb_audio_sample_fifo;

  localparam int c_DEPTH_LOG2 = 3;
  localparam int c_DEPTH      = 1 << c_DEPTH_LOG2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [15:0]            in_left = 16'h0;
  logic [15:0]            in_right = 16'h0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic                   flush = 1'b0;
  logic                   lrck = 1'b0;
  logic [15:0]            left;
  logic [15:0]            right;
  logic [c_DEPTH_LOG2:0]  level;
  logic                   underrun;
  logic [7:0]             underrun_count;

  audio_sample_fifo #(.DEPTH_LOG2(c_DEPTH_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush), .lrck(lrck),
    .left(left), .right(right), .level(level), .underrun(underrun),
    .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] l;
    logic [15:0] r;
    logic        u;
  } ev_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          mcyc     = 0;
  logic [31:0] m_fifo[$];
  int          m_pop_due[$];
  ev_t         m_events[$];
  int          m_count  = 0;
  logic        m_prev_lrck = 1'b0;
  logic [15:0] m_out_l  = 16'h8000;
  logic [15:0] m_out_r  = 16'h8000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pairs in a queue, pops scheduled two edges after lrck is seen high.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_fifo.delete();
        m_pop_due.delete();
        m_events.delete();
        m_count     = 0;
        m_prev_lrck = 1'b0;
        m_out_l     = 16'h8000;
        m_out_r     = 16'h8000;
      end else begin
        bit do_pop;
        bit can_push;
        ev_t e;
        mcyc++;
        if (lrck && !m_prev_lrck) m_pop_due.push_back(mcyc + 2);
        m_prev_lrck = lrck;
        do_pop = (m_pop_due.size() > 0) && (m_pop_due[0] == mcyc);
        if (do_pop) void'(m_pop_due.pop_front());
        if (flush) begin
          m_fifo.delete();
          m_out_l = 16'h8000;
          m_out_r = 16'h8000;
          e.cyc = mcyc; e.l = m_out_l; e.r = m_out_r; e.u = 1'b0;
          m_events.push_back(e);
        end else begin
          can_push = in_valid && (m_fifo.size() < c_DEPTH);
          if (do_pop) begin
            if (m_fifo.size() > 0) begin
              logic [31:0] p;
              p = m_fifo.pop_front();
              m_out_l = p[31:16];
              m_out_r = p[15:0];
              e.u = 1'b0;
            end else begin
              e.u = 1'b1;
              if (m_count < 255) m_count++;
            end
            e.cyc = mcyc; e.l = m_out_l; e.r = m_out_r;
            m_events.push_back(e);
          end
          if (can_push) m_fifo.push_back({in_left, in_right});
        end
      end
    end
  end

  // Monitor: compares DUT outputs mid-cycle against the scoreboard.
  initial begin
    logic [15:0] held_l;
    logic [15:0] held_r;
    held_l = 16'h8000;
    held_r = 16'h8000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_l = 16'h8000;
        held_r = 16'h8000;
      end
      if (m_events.size() > 0 && m_events[0].cyc == mcyc) begin
        ev_t e;
        e = m_events.pop_front();
        chk("event_left", {16'h0, left}, {16'h0, e.l});
        chk("event_right", {16'h0, right}, {16'h0, e.r});
        chk("event_underrun", {31'h0, underrun}, {31'h0, e.u});
        held_l = e.l;
        held_r = e.r;
      end else begin
        chk("hold_left", {16'h0, left}, {16'h0, held_l});
        chk("hold_right", {16'h0, right}, {16'h0, held_r});
        chk("no_underrun", {31'h0, underrun}, 32'h0);
      end
      chk("level", {28'h0, level}, m_fifo.size());
      chk("in_ready", {31'h0, in_ready}, {31'h0, (m_fifo.size() < c_DEPTH) && !flush});
      chk("underrun_count", {24'h0, underrun_count}, m_count);
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    in_valid = 1'b1; in_left = l; in_right = r;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic lrck_frame();
    lrck = 1'b1;
    tick(2);
    lrck = 1'b0;
    tick(2);
  endtask

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Two pairs out in order
    push(16'h1111, 16'h2222);
    push(16'h3333, 16'h4444);
    lrck_frame();
    lrck_frame();
    tick(2);

    // Fill to full, offer a ninth, then free one slot
    for (int i = 0; i < c_DEPTH; i++) push(16'hA000 + 16'(i), 16'h5000 + 16'(i));
    chk("full_ready_low", {31'h0, in_ready}, 32'h0);
    push(16'hDEAD, 16'hBEEF);
    lrck_frame();
    chk("ready_after_pop", {31'h0, in_ready}, 32'h1);
    for (int i = 0; i < c_DEPTH; i++) lrck_frame();

    // Underrun saturation on an empty FIFO
    for (int i = 0; i < 300; i++) lrck_frame();
    chk("underrun_saturated", {24'h0, underrun_count}, 32'd255);

    // Simultaneous push and pop at level 3
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 3; i++) push(16'h0100 + 16'(i), 16'h0200 + 16'(i));
    lrck = 1'b1;
    tick(2);
    in_valid = 1'b1; in_left = 16'h0777; in_right = 16'h0888;
    tick();
    in_valid = 1'b0; lrck = 1'b0;
    chk("level_push_pop", {28'h0, level}, 32'd3);
    tick(2);
    for (int i = 0; i < 3; i++) lrck_frame();

    // Flush at level 5 with in_valid high
    for (int i = 0; i < 5; i++) push(16'h1234 + 16'(i), 16'h4321 + 16'(i));
    flush = 1'b1; in_valid = 1'b1; in_left = 16'hCAFE; in_right = 16'hF00D;
    #1;
    chk("flush_ready_low", {31'h0, in_ready}, 32'h0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_level", {28'h0, level}, 32'd0);
    chk("flush_left", {16'h0, left}, 32'h8000);

    // Asynchronous reset mid-frame at level 4
    for (int i = 0; i < 4; i++) push(16'h6000 + 16'(i), 16'h7000 + 16'(i));
    lrck_frame();
    lrck = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_left", {16'h0, left}, 32'h8000);
    chk("rst_right", {16'h0, right}, 32'h8000);
    chk("rst_level", {28'h0, level}, 32'd0);
    chk("rst_count", {24'h0, underrun_count}, 32'd0);
    chk("rst_underrun", {31'h0, underrun}, 32'd0);
    lrck = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    lrck_frame();
    chk("post_reset_underrun", {24'h0, underrun_count}, 32'd1);

    // Randomized traffic
    begin
      int half;
      half = 3;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        int bias;
        bias = ((cyc / 500) % 2 == 0) ? 2 : 7;
        in_valid = ($urandom_range(0, 9) < bias);
        in_left  = 16'($urandom);
        in_right = 16'($urandom);
        flush    = ($urandom_range(0, 299) == 0);
        if (--half == 0) begin
          lrck = ~lrck;
          half = $urandom_range(2, 6);
        end
        tick();
      end
      in_valid = 1'b0; flush = 1'b0; lrck = 1'b0;
      tick(6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/audio_sample_fifo.md
AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 3, meaning the FIFO holds 2^DEPTH_LOG2 stereo sample pairs.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_left, input, 16 bits: left sample from the producer, unsigned offset-binary (0x8000 = silence).
REQ-005 The block SHALL have port in_right, input, 16 bits: right sample from the producer, same format as in_left.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the in_left/in_right pair is offered this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the pair this cycle.
REQ-008 The block SHALL have port flush, input, 1 bit: synchronous clear of FIFO contents.
REQ-009 The block SHALL have port lrck, input, 1 bit: word clock from the downstream DAC serializer, asynchronous to clk.
REQ-010 The block SHALL have port left, output, 16 bits: current left sample to the DAC, registered.
REQ-011 The block SHALL have port right, output, 16 bits: current right sample to the DAC, registered.
REQ-012 The block SHALL have port level, output, DEPTH_LOG2+1 bits: number of pairs stored.
REQ-013 The block SHALL have port underrun, output, 1 bit: one-cycle pulse on a pop attempted while empty.
REQ-014 The block SHALL have port underrun_count, output, 8 bits: count of underrun events, saturating.

Function
REQ-015 lrck SHALL pass through a 2-flop synchronizer plus one history flop; a pop request (pop_req) is the single-cycle rising edge of the synchronized lrck.
REQ-016 Outputs SHALL update only on a rising lrck edge, giving the DAC half a frame of setup before it latches on the falling edge.
REQ-017 Pop-request latency SHALL be fixed: left/right change exactly 3 clk cycles after lrck rises at the synchronizer input.
REQ-018 in_ready SHALL equal (level != 2^DEPTH_LOG2) AND NOT flush, as a combinational function of registered state.
REQ-019 A push SHALL occur when in_valid AND in_ready; the pair is written at the write pointer, which increments modulo 2^DEPTH_LOG2.
REQ-020 On pop_req with level > 0, left/right SHALL load the oldest pair next cycle, and the read pointer SHALL increment modulo 2^DEPTH_LOG2.
REQ-021 On pop_req with level == 0, left/right SHALL hold their previous values, underrun SHALL pulse high for 1 cycle, and underrun_count SHALL increment, saturating at 255.
REQ-022 A simultaneous push and pop SHALL both take effect with level unchanged; when full, in_ready is low, so no push occurs that cycle even if a pop occurs.
REQ-023 A push into an empty FIFO and a pop_req in the same cycle SHALL count as an underrun; the new pair is stored and level becomes 1.
REQ-024 Pointers SHALL be DEPTH_LOG2+1 bits with the extra wrap bit; full = MSBs differ and lower bits equal; empty = pointers equal; level = wr_ptr - rd_ptr modulo 2^(DEPTH_LOG2+1).
REQ-025 flush SHALL take priority over push and pop: next cycle, pointers and level are 0 and left/right = 0x8000.
REQ-026 flush SHALL leave underrun_count unchanged, and any pop_req in the flush cycle SHALL be discarded without an underrun pulse.
REQ-027 Sample data SHALL pass through unmodified: no scaling, sign conversion or truncation.

Reset
REQ-028 While rst_n is low, asynchronously: left = right = 0x8000, level = 0, underrun = 0, underrun_count = 0, pointers = 0, and synchronizer flops = 0.
REQ-029 in_ready SHALL be high one cycle after rst_n deasserts, provided flush is low.
REQ-030 Reset asserted mid-operation SHALL discard all stored pairs; no stale pair appears after release.
REQ-031 The first lrck rising edge after release, with the FIFO empty, SHALL produce an underrun.

Verification
REQ-032 Push 0x1111/0x2222, then 0x3333/0x4444, then toggle lrck -> left/right = 0x1111/0x2222 3 cycles after the first rise and 0x3333/0x4444 after the second; level goes 2 -> 1 -> 0.
REQ-033 Push 8 pairs (DEPTH_LOG2=3) with no lrck -> in_ready low and level = 8; a 9th in_valid is not accepted; one lrck rise -> in_ready high again.
REQ-034 Empty FIFO, 300 lrck rises -> 300 underrun pulses, underrun_count = 255, outputs held at 0x8000.
REQ-035 Push and pop in the same cycle with level = 3 -> level stays 3 and FIFO order is preserved.
REQ-036 flush with level = 5 while in_valid is high -> in_ready low that cycle; next cycle level = 0 and left/right = 0x8000; underrun_count unchanged.
REQ-037 Assert rst_n low with level = 4 mid-frame -> all outputs reach reset values immediately without waiting for a clk edge; after release, the next lrck rise produces an underrun and outputs stay at 0x8000.
